bit_interleaver: RTL and testbench

BIT_INTERLEAVER -- requirements
Module: bit_interleaver

---
 rtl/bit_interleaver.sv | 139 +++++++++++++
 tb/tb_bit_interleaver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_interleaver.sv
// Single-bit-per-subcarrier block interleaver: ping-pong banks are written in
// permuted order and read out sequentially, one bit per cycle.
module bit_interleaver #(
  parameter int N_CBPS = 48
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Input,
  input  logic InValid,
  output logic Output,
  output logic OutValid,
  output logic SymbolDone,
  output logic read_state
);

  // Handshake: Input is taken on every edge with InValid=1 (no backpressure);
  // Output is meaningful exactly in cycles with OutValid=1.

  localparam int CW = $clog2(N_CBPS);
  localparam logic [CW-1:0] LAST = CW'(N_CBPS - 1);
  localparam logic [CW-1:0] ROWS = CW'(N_CBPS / 16);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_t;

  logic [N_CBPS-1:0] bank [2];
  logic              wr_bank;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     k_eff;
  logic [CW-1:0]     wr_addr;
  logic              wr_last;

  rd_state_t     state, state_n;
  logic          rd_bank, rd_bank_n;
  logic [CW-1:0] rd_cnt, rd_cnt_n;
  logic [1:0]    pend, pend_n;
  logic          launch;
  logic          launch_bank;
  logic          out_n, valid_n, done_n;

  // Start restarts the symbol, so the bit arriving with it becomes k=0.
  always_comb begin
    k_eff   = Start ? '0 : wr_cnt;
    wr_addr = ROWS * CW'(k_eff[3:0]) + (k_eff >> 4);
    wr_last = InValid && (k_eff == LAST);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (InValid) begin
      wr_cnt <= wr_last ? '0 : k_eff + CW'(1);
      if (wr_last) wr_bank <= ~wr_bank;
    end else if (Start) begin
      wr_cnt <= '0;
    end
  end

  // Bank storage carries no reset; stale contents are never read because
  // only a completed symbol ever becomes pending.
  always_ff @(posedge Clock) begin
    if (!Reset && InValid) bank[wr_bank][wr_addr] <= Input;
  end

  always_comb begin
    state_n     = state;
    rd_bank_n   = rd_bank;
    rd_cnt_n    = rd_cnt;
    pend_n      = pend;
    launch      = 1'b0;
    launch_bank = 1'b0;
    out_n       = 1'b0;
    valid_n     = 1'b0;
    done_n      = 1'b0;

    if (wr_last) pend_n[wr_bank] = 1'b1;

    // A just-completed bank launches on its own final write edge: address 0
    // (k=0) was stored earlier, so its first bit is already available.
    if (state == RD_IDLE) begin
      if (wr_last) begin
        launch      = 1'b1;
        launch_bank = wr_bank;
      end else if (pend[0]) begin
        launch      = 1'b1;
        launch_bank = 1'b0;
      end else if (pend[1]) begin
        launch      = 1'b1;
        launch_bank = 1'b1;
      end
    end

    if (launch) begin
      pend_n[launch_bank] = 1'b0;
      out_n     = bank[launch_bank][0];
      valid_n   = 1'b1;
      rd_bank_n = launch_bank;
      rd_cnt_n  = CW'(1);
      state_n   = RD_BUSY;
    end else if (state == RD_BUSY) begin
      out_n   = bank[rd_bank][rd_cnt];
      valid_n = 1'b1;
      done_n  = (rd_cnt == LAST);
      if (rd_cnt == LAST) begin
        rd_cnt_n = '0;
        state_n  = RD_IDLE;
      end else begin
        rd_cnt_n = rd_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= RD_IDLE;
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
      pend       <= '0;
      Output     <= 1'b0;
      OutValid   <= 1'b0;
      SymbolDone <= 1'b0;
    end else begin
      state      <= state_n;
      rd_bank    <= rd_bank_n;
      rd_cnt     <= rd_cnt_n;
      pend       <= pend_n;
      Output     <= out_n;
      OutValid   <= valid_n;
      SymbolDone <= done_n;
    end
  end

  assign read_state = state;

endmodule

// File: tb/tb_bit_interleaver.sv
// Directed bench for bit_interleaver (N_CBPS=48): expected output vectors are
// hand-computed or derived from the inverse permutation j -> k.
module tb_bit_interleaver;

  logic Clock = 1'b0;
  logic Reset, Start, Input, InValid;
  logic Output, OutValid, SymbolDone, read_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;

  logic out_q[$];
  int   done_q[$];
  int   vcyc_q[$];

  bit_interleaver #(.N_CBPS(48)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Input     (Input),
    .InValid   (InValid),
    .Output    (Output),
    .OutValid  (OutValid),
    .SymbolDone(SymbolDone),
    .read_state(read_state)
  );

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge Clock) begin
    cyc++;
    if (mon_on) begin
      if (OutValid === 1'b1) begin
        out_q.push_back(Output);
        vcyc_q.push_back(cyc);
        if (SymbolDone === 1'b1) done_q.push_back(out_q.size());
      end else begin
        check("idle_output", 64'(Output), 64'd0);
        check("idle_symboldone", 64'(SymbolDone), 64'd0);
      end
    end
  end

  function automatic logic [47:0] q_slice(input int off);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < 48; i++)
      if (off + i < out_q.size()) v[i] = out_q[off + i];
    return v;
  endfunction

  function automatic int done_at(input int i);
    return (i < done_q.size()) ? done_q[i] : -1;
  endfunction

  function automatic int span();
    return (vcyc_q.size() > 0) ? vcyc_q[$] - vcyc_q[0] + 1 : 0;
  endfunction

  // Inverse view of the permutation: output index j carries k = 16*(j%3) + j/3.
  function automatic logic [47:0] perm(input logic [47:0] v);
    logic [47:0] r;
    for (int j = 0; j < 48; j++) r[j] = v[16 * (j % 3) + j / 3];
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    Start   = 1'b0;
    Input   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_caps();
    out_q.delete();
    done_q.delete();
    vcyc_q.delete();
  endtask

  task automatic send_sym(input logic [47:0] v, input bit start_first);
    for (int k = 0; k < 48; k++) begin
      Start   = start_first && (k == 0);
      Input   = v[k];
      InValid = 1'b1;
      tick();
    end
    Start   = 1'b0;
    InValid = 1'b0;
    Input   = 1'b0;
  endtask

  task automatic check_single(input string tag, input logic [47:0] exp_bits);
    check({tag, "_count"}, 64'(out_q.size()), 64'd48);
    check({tag, "_bits"}, 64'(q_slice(0)), 64'(exp_bits));
    check({tag, "_done_n"}, 64'(done_q.size()), 64'd1);
    check({tag, "_done_at"}, 64'(done_at(0)), 64'd48);
    check({tag, "_gapless"}, 64'(span()), 64'd48);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [47:0] q_pat;
    Reset = 1'b1; Start = 1'b0; Input = 1'b0; InValid = 1'b0;
    tick();
    tick();
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_output", 64'(Output), 64'd0);
    check("rst_symboldone", 64'(SymbolDone), 64'd0);
    check("rst_read_state", 64'(read_state), 64'd0);
    Reset  = 1'b0;
    mon_on = 1'b1;

    // Single 1 at k=1 lands on output index 3.
    clear_caps();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    send_sym(48'h0000_0000_0002, 1'b0);
    check("k1_latency", 64'(OutValid), 64'd1);
    check("k1_first", 64'(Output), 64'd0);
    idle(55);
    check_single("k1", 48'h0000_0000_0008);

    // Single 1 at k=16 -> index 1.
    clear_caps();
    send_sym(48'h0000_0001_0000, 1'b1);
    check("k16_latency", 64'(OutValid), 64'd1);
    idle(55);
    check_single("k16", 48'h0000_0000_0002);

    // Single 1 at k=47 (written on the completing edge) -> index 47.
    clear_caps();
    send_sym(48'h8000_0000_0000, 1'b1);
    check("k47_latency", 64'(OutValid), 64'd1);
    idle(55);
    check_single("k47", 48'h8000_0000_0000);

    // Back-to-back symbols: all ones then all zeros, gapless.
    clear_caps();
    send_sym(48'hFFFF_FFFF_FFFF, 1'b1);
    send_sym(48'h0000_0000_0000, 1'b0);
    idle(55);
    check("b2b_count", 64'(out_q.size()), 64'd96);
    check("b2b_sym_a", 64'(q_slice(0)), 64'hFFFF_FFFF_FFFF);
    check("b2b_sym_b", 64'(q_slice(48)), 64'd0);
    check("b2b_done_n", 64'(done_q.size()), 64'd2);
    check("b2b_done_a", 64'(done_at(0)), 64'd48);
    check("b2b_done_b", 64'(done_at(1)), 64'd96);
    check("b2b_gapless", 64'(span()), 64'd96);

    // 20 bits, then Start with a valid bit, then 47 more: only post-Start bits
    // form the symbol (ones at k=0 and k=5 -> indices 0 and 15).
    clear_caps();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      Input   = 1'b1;
      InValid = 1'b1;
      tick();
    end
    send_sym(48'h0000_0000_0021, 1'b1);
    idle(55);
    check_single("restart", 48'h0000_0000_8001);

    // Reset while output index 10 is on the port aborts the readout.
    clear_caps();
    send_sym(48'hFFFF_FFFF_FFFF, 1'b1);
    check("abort_latency", 64'(OutValid), 64'd1);
    idle(10);
    check("abort_idx10_valid", 64'(OutValid), 64'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_outvalid", 64'(OutValid), 64'd0);
    check("abort_output", 64'(Output), 64'd0);
    check("abort_symboldone", 64'(SymbolDone), 64'd0);
    idle(60);
    check("abort_count", 64'(out_q.size()), 64'd11);
    check("abort_done_n", 64'(done_q.size()), 64'd0);

    // A partial symbol after reset is never output.
    clear_caps();
    for (int i = 0; i < 20; i++) begin
      Input   = 1'b1;
      InValid = 1'b1;
      tick();
    end
    idle(60);
    check("partial_count", 64'(out_q.size()), 64'd0);

    // A fresh full symbol after the discarded partial comes out normally.
    clear_caps();
    send_sym(48'h0000_0000_0002, 1'b1);
    idle(55);
    check_single("post_abort", 48'h0000_0000_0008);

    // InValid toggling 1,0,...: invalid cycles carry junk Input=1.
    clear_caps();
    q_pat = 48'hA5C3_0F1E_7B29;
    for (int i = 0; i < 96; i++) begin
      InValid = (i % 2 == 0);
      Input   = (i % 2 == 0) ? q_pat[i / 2] : 1'b1;
      tick();
      if (i == 94) begin
        check("toggle_no_early", 64'(vcyc_q.size()), 64'd0);
        check("toggle_latency", 64'(OutValid), 64'd1);
        check("toggle_first", 64'(Output), 64'(q_pat[0]));
      end
    end
    idle(55);
    check_single("toggle", perm(q_pat));

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
